// File: rtl/game_controller.sv
// rtl/game_controller.sv - Flappy Bird game sequencer: tick, FSM, bird physics, pipes, score (optional GAP_LFSR_EN)
module game_controller #(
    parameter int TICK_DIV   = 100000,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BIRD_X     = 100,
    parameter int BIRD_SIZE  = 40,
    parameter int BIRD_Y0    = 220,
    parameter int PIPE_W     = 60,
    parameter int PIPE_SPEED = 2,
    parameter int GAP_H      = 140,
    parameter int GRAVITY    = 1,
    parameter int FLAP_VEL   = 8,
    parameter int MAX_FALL   = 8,
    parameter int OVER_HOLD  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pressed,
    output logic       tick,
    output logic [1:0] state,
    output logic [9:0] bird_y,
    output logic [9:0] pipe_x,
    output logic [9:0] gap_y,
    output logic [7:0] score
);
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(OVER_HOLD + 1);
    localparam logic [9:0] GAP_Y0 = 10'd160;
    localparam logic signed [5:0] GRAV_V   = 6'(GRAVITY);
    localparam logic signed [5:0] MAX_V    = 6'(MAX_FALL);
    localparam logic signed [5:0] FLAP_V   = 6'(-FLAP_VEL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    state_t             st;
    logic [CNT_W-1:0]   tick_cnt;
    logic               btn_prev;
    logic               flap_req;
    logic               flap_now;
    logic signed [5:0]  vel;
    logic signed [5:0]  vel_inc;
    logic signed [5:0]  vel_nxt;
    logic signed [10:0] ny;
    logic [10:0]        by_w;
    logic [10:0]        px_w;
    logic [10:0]        gy_w;
    logic [9:0]         by_nxt;
    logic [9:0]         px_nxt;
    logic [9:0]         next_gap;
    logic               hit;
    logic               floor_hit;
    logic               wrap;
    logic               scored;
    logic               scored_keep;
    logic               score_evt;
    logic               restart;
    logic [HOLD_W-1:0]  hold_cnt;

    assign state    = st;
    assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign flap_now = flap_req | (btn_pressed & ~btn_prev);
    assign restart  = (st == ST_OVER) && flap_now && (hold_cnt == HOLD_W'(OVER_HOLD));

    // Free-running game tick divider, never stopped by the FSM
    always_ff @(posedge clk) begin
        if (!rst_n || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Button rising-edge detector; the request sticks until a tick consumes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_prev <= 1'b0;
            flap_req <= 1'b0;
        end else begin
            btn_prev <= btn_pressed;
            flap_req <= tick ? 1'b0 : flap_now;
        end
    end

    // PLAY datapath: collision, velocity, vertical move, pipe scroll and score
    always_comb begin
        by_w      = {1'b0, bird_y};
        px_w      = {1'b0, pipe_x};
        gy_w      = {1'b0, gap_y};
        hit       = (px_w < 11'(BIRD_X + BIRD_SIZE)) && (px_w + 11'(PIPE_W) > 11'(BIRD_X)) &&
                    ((by_w < gy_w) || (by_w + 11'(BIRD_SIZE) > gy_w + 11'(GAP_H)));
        vel_inc   = vel + GRAV_V;
        vel_nxt   = flap_now ? FLAP_V : ((vel_inc > MAX_V) ? MAX_V : vel_inc);
        ny        = $signed(by_w) + 11'(vel_nxt);
        floor_hit = 1'b0;
        by_nxt    = ny[9:0];
        if (ny < 11'sd0) begin
            by_nxt = '0;
        end else if (ny >= 11'(SCREEN_H - BIRD_SIZE)) begin
            by_nxt    = 10'(SCREEN_H - BIRD_SIZE);
            floor_hit = 1'b1;
        end
        wrap        = (pipe_x <= 10'(PIPE_SPEED));
        px_nxt      = wrap ? 10'(SCREEN_W) : pipe_x - 10'(PIPE_SPEED);
        scored_keep = scored & ~wrap;
        score_evt   = (({1'b0, px_nxt} + 11'(PIPE_W)) < 11'(BIRD_X)) && !scored_keep;
    end

`ifdef GAP_LFSR_EN
    logic [7:0] lfsr;

    // Gap randomiser: x^8+x^6+x^5+x^4+1 Fibonacci LFSR, stepping every clock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign next_gap = 10'd40 + {2'b00, lfsr};
`else
    logic [1:0] gap_idx;

    // Gap table index: points at the gap the next reloaded pipe will use
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_idx <= 2'd1;
        end else if (tick && restart) begin
            gap_idx <= 2'd1;
        end else if (tick && (st == ST_PLAY) && !hit && wrap) begin
            gap_idx <= gap_idx + 2'd1;
        end
    end

    // Fixed gap table lookup
    always_comb begin
        case (gap_idx)
            2'd0:    next_gap = 10'd160;
            2'd1:    next_gap = 10'd80;
            2'd2:    next_gap = 10'd240;
            default: next_gap = 10'd120;
        endcase
    end
`endif

    // Game FSM; every game-state register only moves on tick cycles
    always_ff @(posedge clk) begin
        if (!rst_n || (tick && restart)) begin
            st       <= ST_IDLE;
            bird_y   <= 10'(BIRD_Y0);
            vel      <= '0;
            pipe_x   <= 10'(SCREEN_W);
            gap_y    <= GAP_Y0;
            score    <= '0;
            scored   <= 1'b0;
            hold_cnt <= '0;
        end else if (tick) begin
            case (st)
                ST_IDLE: begin
                    if (flap_now) begin
                        st     <= ST_PLAY;
                        vel    <= FLAP_V;
                        bird_y <= 10'(BIRD_Y0 - FLAP_VEL);
                    end
                end
                ST_PLAY: begin
                    if (hit) begin
                        st <= ST_OVER;
                    end else begin
                        vel    <= vel_nxt;
                        bird_y <= by_nxt;
                        pipe_x <= px_nxt;
                        scored <= scored_keep | score_evt;
                        if (floor_hit) st <= ST_OVER;
                        if (wrap) gap_y <= next_gap;
                        if (score_evt && (score != 8'hFF)) score <= score + 8'd1;
                    end
                end
                ST_OVER: begin
                    if (hold_cnt < HOLD_W'(OVER_HOLD)) hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule
